per_uart_tx: RTL

- UART transmitter peripheral for the openMSP430 peripheral bus; sits downstream of the core's per_* outputs, alongside the LED register.
- Software writes bytes into a small TX FIFO through memory-mapped registers.
- An FSM serialises each byte on txd as 8N1 at a programmable baud divisor.
- Gives firmware a debug/console output independent of the debug UART.

---
 rtl/per_uart_tx_pkg.sv | 35 +++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/per_uart_tx.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/per_uart_tx_pkg.sv
// per_uart_tx_pkg
// Shared definitions for the per_uart_tx peripheral:
//   - word offsets of the four registers relative to BASE_ADDR
//   - bit positions inside CTRL and STATUS
//   - 2-bit encodings of the transmit FSM states
package per_uart_tx_pkg;

    // Register word offsets from BASE_ADDR
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_BAUD   = 2'd1;
    localparam logic [1:0] REG_TXDATA = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_FLUSH_BIT = 1;
    localparam int CTRL_IE_BIT    = 2;

    // STATUS bit positions
    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_EMPTY_BIT = 2;
    localparam int STAT_OVF_BIT   = 3;
    localparam int STAT_LEVEL_LSB = 8;
    localparam int STAT_LEVEL_W   = 5;

    // Transmit FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock show-ahead FIFO. dout always presents the oldest entry, so a
// consumer can take it in the same cycle it asserts pop.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : synchronous flush; wins over push and pop in the same cycle
//   push, din : write request and data; ignored when full unless popping
//   pop       : read request; ignored when empty
//   dout      : head entry (valid while !empty)
//   full, empty, level : occupancy flags and entry count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign level = count;
    assign dout  = mem[rd_ptr];

    // A push into a full FIFO is still accepted when a pop frees a slot in
    // the same cycle. DEPTH is a power of two so the pointers wrap naturally.
    assign do_pop  = pop & ~empty & ~clear;
    assign do_push = push & ~clear & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/per_uart_tx.sv
// per_uart_tx
// UART transmitter on the openMSP430 peripheral bus. Firmware queues bytes
// through TXDATA; the FSM sends each one as 8N1 on txd, every bit lasting
// BAUD+1 clk cycles.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   per_addr  : peripheral word address
//   per_din   : write data
//   per_en    : access strobe
//   per_we    : byte write enables, [0] = low byte; 0 means read
//   per_dout  : read data, 0 when this block is not addressed
//   txd       : serial output, idle high
//   irq_tx    : FIFO empty and CTRL.IE set (registered)
module per_uart_tx
    import per_uart_tx_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR  = 8'h08,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    output logic        txd,
    output logic        irq_tx
);

    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    // Bus decode
    logic [7:0] offset;
    logic [1:0] reg_off;
    logic       in_block;
    logic       wr_access;
    logic       rd_access;
    logic       ctrl_wr;
    logic       baud_wr_lo;
    logic       baud_wr_hi;
    logic       txdata_wr;
    logic       status_wr;
    logic       flush_req;

    // Register state
    logic        ctrl_en;
    logic        ctrl_ie;
    logic [15:0] baud;
    logic        ovf;
    logic [15:0] status_word;

    // FIFO interface
    logic             fifo_push;
    logic             fifo_pop;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;

    // Transmit engine
    tx_state_t   state;
    tx_state_t   state_next;
    logic [15:0] baud_cnt;
    logic [15:0] baud_cnt_next;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_idx_next;
    logic [7:0]  shift;
    logic [7:0]  shift_next;
    logic        txd_next;

    // Offsets 0..3 from BASE_ADDR select this block; the subtraction wraps
    // so addresses below the base fall outside.
    assign offset    = per_addr - BASE_ADDR;
    assign reg_off   = offset[1:0];
    assign in_block  = (offset[7:2] == 6'd0);
    assign wr_access = per_en & (|per_we) & in_block;
    assign rd_access = per_en & (per_we == 2'b00) & in_block;

    assign ctrl_wr    = wr_access & (reg_off == REG_CTRL)   & per_we[0];
    assign baud_wr_lo = wr_access & (reg_off == REG_BAUD)   & per_we[0];
    assign baud_wr_hi = wr_access & (reg_off == REG_BAUD)   & per_we[1];
    assign txdata_wr  = wr_access & (reg_off == REG_TXDATA) & per_we[0];
    assign status_wr  = wr_access & (reg_off == REG_STATUS) & per_we[0];
    assign flush_req  = ctrl_wr & per_din[CTRL_FLUSH_BIT];

    // A flush in the same cycle as a push discards the byte without OVF.
    assign fifo_push = txdata_wr & ~flush_req;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush_req),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (per_din[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Control, divisor and overflow registers. OVF only latches for a push
    // that truly lost its byte, i.e. no pop freed a slot in that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_en <= 1'b0;
            ctrl_ie <= 1'b0;
            baud    <= DIV_RESET;
            ovf     <= 1'b0;
            irq_tx  <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                ctrl_en <= per_din[CTRL_EN_BIT];
                ctrl_ie <= per_din[CTRL_IE_BIT];
            end
            if (baud_wr_lo) begin
                baud[7:0] <= per_din[7:0];
            end
            if (baud_wr_hi) begin
                baud[15:8] <= per_din[15:8];
            end
            if (fifo_push && fifo_full && !fifo_pop) begin
                ovf <= 1'b1;
            end else if (status_wr && per_din[STAT_OVF_BIT]) begin
                ovf <= 1'b0;
            end
            irq_tx <= ctrl_ie & fifo_empty;
        end
    end

    always_comb begin
        status_word = 16'h0000;
        status_word[STAT_BUSY_BIT]  = (state != ST_IDLE);
        status_word[STAT_FULL_BIT]  = fifo_full;
        status_word[STAT_EMPTY_BIT] = fifo_empty;
        status_word[STAT_OVF_BIT]   = ovf;
        status_word[STAT_LEVEL_LSB +: STAT_LEVEL_W] = STAT_LEVEL_W'(fifo_level);
    end

    // Read data is zero whenever this block is not the one being read,
    // because the peripheral bus ORs all slaves together.
    always_comb begin
        per_dout = 16'h0000;
        if (rd_access) begin
            case (reg_off)
                REG_CTRL: begin
                    per_dout[CTRL_EN_BIT] = ctrl_en;
                    per_dout[CTRL_IE_BIT] = ctrl_ie;
                end
                REG_BAUD:   per_dout = baud;
                REG_STATUS: per_dout = status_word;
                default:    per_dout = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
            txd      <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_idx  <= bit_idx_next;
            shift    <= shift_next;
            txd      <= txd_next;
        end
    end

    // Every bit is held until the counter reaches zero, then the counter is
    // reloaded from the live BAUD register, so a divisor change lands on the
    // next bit boundary. The current data bit is always shift[0].
    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt;
        bit_idx_next  = bit_idx;
        shift_next    = shift;
        fifo_pop      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (ctrl_en && !fifo_empty) begin
                    fifo_pop      = 1'b1;
                    shift_next    = fifo_dout;
                    baud_cnt_next = baud;
                    bit_idx_next  = 3'd0;
                    state_next    = ST_START;
                end
            end
            ST_START: begin
                if (baud_cnt == 16'd0) begin
                    baud_cnt_next = baud;
                    state_next    = ST_DATA;
                end else begin
                    baud_cnt_next = baud_cnt - 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_cnt == 16'd0) begin
                    baud_cnt_next = baud;
                    if (bit_idx == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        shift_next   = {1'b0, shift[7:1]};
                    end
                end else begin
                    baud_cnt_next = baud_cnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_cnt == 16'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    baud_cnt_next = baud_cnt - 16'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // txd is registered from the next-state view so it changes on the
        // same edge as the state and never glitches.
        case (state_next)
            ST_START: txd_next = 1'b0;
            ST_DATA:  txd_next = shift_next[0];
            default:  txd_next = 1'b1;
        endcase
    end

endmodule
